// File: rtl/conv2_ctrl_if.sv
// Handshake bundle between the conv-2 sequencer (master) and its surroundings
// (network controller, feature buffer, weight/bias ROMs, datapath, output buffer).
interface conv2_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] fb_addr;
    logic [7:0] wt_addr;
    logic [2:0] bias_addr;
    logic       dp_valid_i;
    logic       dp_valid_o;
    logic       ob_we;
    logic [6:0] ob_addr;

    modport master (
        input  start, dp_valid_o,
        output busy, done, err, fb_addr, wt_addr, bias_addr, dp_valid_i, ob_we, ob_addr
    );

    modport slave (
        output start, dp_valid_o,
        input  busy, done, err, fb_addr, wt_addr, bias_addr, dp_valid_i, ob_we, ob_addr
    );
endinterface

// File: rtl/conv2_ctrl.sv
// Layer-2 convolution sequencer: walks output channels (outer) and 4-row windows (inner).
// Optional DRAIN watchdog enabled by defining CONV2_CTRL_TIMEOUT_EN.
module conv2_ctrl #(
    parameter int IN_ROWS   = 20,
    parameter int WIN_ROWS  = 4,
    parameter int OUT_CH    = 8,
    parameter int PASS_CYC  = 18
`ifdef CONV2_CTRL_TIMEOUT_EN
    ,
    parameter int DRAIN_MAX = 15
`endif
) (
    input  logic          clk,
    input  logic          rst,
    conv2_ctrl_if.master  bus
);

    localparam int NWIN = (IN_ROWS - WIN_ROWS) / 2 + 1;
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int OW   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int KW   = (PASS_CYC > 1) ? $clog2(PASS_CYC) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, NEXT, DONE} state_t;

    state_t        state, state_n;
    logic [WW-1:0] win, win_n;
    logic [OW-1:0] oc, oc_n;
    logic [KW-1:0] k, k_n;

`ifdef CONV2_CTRL_TIMEOUT_EN
    localparam int DW = $clog2(DRAIN_MAX + 1);
    logic [DW-1:0] dcnt;
    logic          timeout;
`endif

    always_comb begin
        state_n = state;
        win_n   = win;
        oc_n    = oc;
        k_n     = k;
`ifdef CONV2_CTRL_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state)
            IDLE: begin
                win_n = '0;
                oc_n  = '0;
                k_n   = '0;
                if (bus.start) state_n = LOAD;
            end
            LOAD: begin
                k_n     = '0;
                state_n = RUN;
            end
            RUN: begin
                if (k == KW'(PASS_CYC - 1)) begin
                    k_n     = '0;
                    state_n = DRAIN;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
                // A strobe arriving on the very cycle the limit is hit still wins.
                if (bus.dp_valid_o) begin
                    state_n = NEXT;
                end
`ifdef CONV2_CTRL_TIMEOUT_EN
                else if (dcnt == DW'(DRAIN_MAX)) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end
`endif
            end
            NEXT: begin
                if (oc == OW'(OUT_CH - 1) && win == WW'(NWIN - 1)) begin
                    state_n = DONE;
                end else begin
                    state_n = LOAD;
                    if (win == WW'(NWIN - 1)) begin
                        win_n = '0;
                        oc_n  = oc + 1'b1;
                    end else begin
                        win_n = win + 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            win            <= '0;
            oc             <= '0;
            k              <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.fb_addr    <= '0;
            bus.wt_addr    <= '0;
            bus.bias_addr  <= '0;
            bus.dp_valid_i <= 1'b0;
            bus.ob_we      <= 1'b0;
            bus.ob_addr    <= '0;
        end else begin
            state          <= state_n;
            win            <= win_n;
            oc             <= oc_n;
            k              <= k_n;
            bus.busy       <= (state_n != IDLE);
            bus.done       <= (state_n == DONE);
            bus.dp_valid_i <= (state_n == RUN);
            bus.ob_we      <= (state_n == NEXT);
            if (state_n == LOAD) begin
                bus.fb_addr   <= 5'({win_n, 1'b0});
                bus.bias_addr <= 3'(oc_n);
            end
            if (state_n == RUN) begin
                bus.wt_addr <= 8'(int'(oc_n) * PASS_CYC + int'(k_n));
            end
            if (state_n == NEXT) begin
                bus.ob_addr <= 7'(int'(oc) * NWIN + int'(win));
            end
`ifdef CONV2_CTRL_TIMEOUT_EN
            if (timeout) bus.err <= 1'b1;
`else
            bus.err <= 1'b0;
`endif
        end
    end

`ifdef CONV2_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
        end else if (state == DRAIN && state_n == DRAIN) begin
            dcnt <= dcnt + 1'b1;
        end else begin
            dcnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_conv2_ctrl.sv
// Bench for conv2_ctrl: reset/start vector table, then whole-layer runs against a
// per-cycle schedule derived from pass arithmetic (LOAD, PASS_CYC RUN, DRAIN, NEXT).
module tb_conv2_ctrl;

    localparam int PASS_CYC  = 18;
    localparam int NWIN      = 9;
    localparam int OUT_CH    = 8;
    localparam int DRAIN_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv2_ctrl_if bus();

    conv2_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       dvi;
        logic       we;
        logic [4:0] fb;
        logic [7:0] wt;
        logic [2:0] bias;
        logic [6:0] oba;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  start;
        logic  dvo;
        outs_t exp;
    } vec_t;

    int    n_vec = 0;
    int    n_bad = 0;
    outs_t exp_q[$];
    bit    dvo_q[$];
    bit    st_q[$];
    outs_t m_last;
    int    we_cnt, done_cyc;
    outs_t snap10;

    function automatic outs_t sample();
        outs_t s;
        s.busy = bus.busy;
        s.done = bus.done;
        s.err  = bus.err;
        s.dvi  = bus.dp_valid_i;
        s.we   = bus.ob_we;
        s.fb   = bus.fb_addr;
        s.wt   = bus.wt_addr;
        s.bias = bus.bias_addr;
        s.oba  = bus.ob_addr;
        return s;
    endfunction

    function automatic outs_t mk(bit busy, bit dvi, int fb, int wt, int bias);
        outs_t o;
        o      = '0;
        o.busy = busy;
        o.dvi  = dvi;
        o.fb   = 5'(fb);
        o.wt   = 8'(wt);
        o.bias = 3'(bias);
        return o;
    endfunction

    task automatic checkOutput(input string name, input int t, input outs_t got, input outs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s cyc=%0d got busy=%b done=%b err=%b dvi=%b we=%b fb=%0d wt=%0d bias=%0d oba=%0d | exp busy=%b done=%b err=%b dvi=%b we=%b fb=%0d wt=%0d bias=%0d oba=%0d",
                     name, t, got.busy, got.done, got.err, got.dvi, got.we, got.fb, got.wt, got.bias, got.oba,
                     exp.busy, exp.done, exp.err, exp.dvi, exp.we, exp.fb, exp.wt, exp.bias, exp.oba);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic d);
        rst            = r;
        bus.start      = s;
        bus.dp_valid_o = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void push(input outs_t o, input bit d, input bit s);
        exp_q.push_back(o);
        dvo_q.push_back(d);
        st_q.push_back(s);
    endfunction

    // Expected per-cycle outputs for one layer; dmode<0 picks a random strobe delay per pass
    // and sprinkles ignored strobes outside DRAIN; wd_pass withholds the strobe on that pass.
    task automatic build_sched(input int dmode, input bit hold_start, input int wd_pass);
        outs_t o;
        int    d;
        bit    stop;
        bit    spur;
        exp_q.delete();
        dvo_q.delete();
        st_q.delete();
        stop   = 1'b0;
        o      = m_last;
        o.busy = 1'b0;
        o.done = 1'b0;
        o.we   = 1'b0;
        o.dvi  = 1'b0;
        push(o, 1'b0, 1'b1);
        for (int p = 0; p < OUT_CH * NWIN && !stop; p++) begin
            d      = (dmode < 0) ? int'($urandom_range(0, 5)) : dmode;
            spur   = (dmode < 0);
            o.busy = 1'b1;
            o.fb   = 5'(2 * (p % NWIN));
            o.bias = 3'(p / NWIN);
            push(o, spur && ($urandom_range(0, 1) == 1), hold_start);
            o.dvi = 1'b1;
            for (int k = 0; k < PASS_CYC; k++) begin
                o.wt = 8'((p / NWIN) * PASS_CYC + k);
                push(o, spur && ($urandom_range(0, 1) == 1), hold_start);
            end
            o.dvi = 1'b0;
            if (p == wd_pass) begin
                for (int j = 0; j <= DRAIN_MAX; j++) push(o, 1'b0, hold_start);
                o.err = 1'b1;
                stop  = 1'b1;
            end else begin
                for (int j = 0; j <= d; j++) push(o, (j == d), hold_start);
                o.we  = 1'b1;
                o.oba = 7'(p);
                push(o, spur && ($urandom_range(0, 1) == 1), hold_start);
                o.we  = 1'b0;
            end
        end
        o.done = 1'b1;
        push(o, 1'b0, hold_start);
        o.done = 1'b0;
        o.busy = 1'b0;
        push(o, 1'b0, hold_start);
        if (hold_start) begin
            o.busy = 1'b1;
            o.fb   = '0;
            o.bias = '0;
            push(o, 1'b0, 1'b0);
        end
        m_last = o;
    endtask

    task automatic run_sched(input string name, input int abort_at);
        outs_t got;
        we_cnt   = 0;
        done_cyc = -1;
        for (int t = 0; t < exp_q.size(); t++) begin
            @(posedge clk);
            #1;
            bus.start      = st_q[t];
            bus.dp_valid_o = dvo_q[t];
            @(negedge clk);
            got = sample();
            checkOutput(name, t, got, exp_q[t]);
            if (got.we) begin
                if (we_cnt == 10) snap10 = got;
                we_cnt++;
            end
            if (got.done && done_cyc < 0) done_cyc = t;
            if (t == abort_at) break;
        end
        bus.start      = 1'b0;
        bus.dp_valid_o = 1'b0;
    endtask

    task automatic reset_and_check(input string name);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput(name, 0, sample(), '0);
        m_last = '0;
    endtask

    initial begin
        vec_t tbl[10];
        bus.start      = 1'b0;
        bus.dp_valid_o = 1'b0;
        m_last         = '0;
        snap10         = '0;

        tbl[0] = '{rst:1'b1, start:1'b1, dvo:1'b0, exp:mk(0, 0, 0, 0, 0)};
        tbl[1] = '{rst:1'b0, start:1'b0, dvo:1'b1, exp:mk(0, 0, 0, 0, 0)};
        tbl[2] = '{rst:1'b0, start:1'b1, dvo:1'b0, exp:mk(1, 0, 0, 0, 0)};
        tbl[3] = '{rst:1'b0, start:1'b1, dvo:1'b1, exp:mk(1, 1, 0, 0, 0)};
        tbl[4] = '{rst:1'b0, start:1'b0, dvo:1'b1, exp:mk(1, 1, 0, 1, 0)};
        tbl[5] = '{rst:1'b0, start:1'b0, dvo:1'b0, exp:mk(1, 1, 0, 2, 0)};
        tbl[6] = '{rst:1'b1, start:1'b0, dvo:1'b0, exp:mk(0, 0, 0, 0, 0)};
        tbl[7] = '{rst:1'b0, start:1'b0, dvo:1'b1, exp:mk(0, 0, 0, 0, 0)};
        tbl[8] = '{rst:1'b0, start:1'b1, dvo:1'b0, exp:mk(1, 0, 0, 0, 0)};
        tbl[9] = '{rst:1'b1, start:1'b0, dvo:1'b0, exp:mk(0, 0, 0, 0, 0)};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].start, tbl[i].dvo);
            checkOutput($sformatf("table%0d", i), i, sample(), tbl[i].exp);
        end
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.dp_valid_o = 1'b0;

        // Reset lands on RUN cycle 7 of pass 5 (LOAD of pass 5 is cycle 116 at D=2).
        $display("[TB] reset mid-pass");
        build_sched(2, 1'b0, -1);
        run_sched("rst_mid_run", 124);
        reset_and_check("rst_mid_zero");

        $display("[TB] nominal layer, D=2");
        build_sched(2, 1'b0, -1);
        run_sched("nominal", -1);
        checkValue("nominal_done_cycle", done_cyc, 1657);
        checkValue("nominal_ob_we_count", we_cnt, 72);
        checkValue("pass10_ob_addr", int'(snap10.oba), 10);
        checkValue("pass10_fb_addr", int'(snap10.fb), 2);
        checkValue("pass10_bias_addr", int'(snap10.bias), 1);
        checkValue("pass10_last_wt", int'(snap10.wt), 35);

        $display("[TB] random delays, spurious strobes, start held high");
        build_sched(-1, 1'b1, -1);
        run_sched("random", -1);
        checkValue("random_ob_we_count", we_cnt, 72);
        reset_and_check("random_reset");

`ifdef CONV2_CTRL_TIMEOUT_EN
        $display("[TB] watchdog on pass 3");
        build_sched(2, 1'b0, 3);
        run_sched("watchdog", -1);
        checkValue("watchdog_ob_we_count", we_cnt, 3);
        checkValue("watchdog_done_cycle", done_cyc, 1 + 3 * 23 + 19 + 16);
        reset_and_check("watchdog_err_clear");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/conv2_ctrl.md
# conv2_ctrl

Sequencer for the second convolution layer's 18-lane PE array. It walks every output channel and every 4-row input window of the layer-2 feature map. Per pass it:
- issues feature-buffer, weight-ROM and bias-ROM addresses;
- drives the datapath's `valid_i` for a fixed pass length;
- waits for the datapath's rescaled result strobe;
- commits the result to the output buffer.

It sits between the layer-1 output buffer/ROMs and the conv-2 datapath, and is started and acknowledged by the top-level network controller.

## Interface
Parameters:
- `IN_ROWS`, 20, input feature-map rows.
- `WIN_ROWS`, 4, rows per window; window stride fixed at 2.
- `OUT_CH`, 8, output channels.
- `PASS_CYC`, 18, cycles `dp_valid_i` is held high per pass.
- `DRAIN_MAX`, 15, watchdog limit in cycles (macro only).

Derived: `NWIN = (IN_ROWS-WIN_ROWS)/2+1` (9 at defaults).

Ports:
- `clk` in 1: sole clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one full layer; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: sticky watchdog flag; held at 0 when the macro is absent.
- `fb_addr` out 5: first input row of the current window (`2*win`).
- `wt_addr` out 8: `oc*PASS_CYC + k`, where k is the RUN cycle index.
- `bias_addr` out 3: current output channel `oc`.
- `dp_valid_i` out 1: datapath input valid.
- `dp_valid_o` in 1: datapath result strobe.
- `ob_we` out 1: output-buffer write enable, one-cycle pulse.
- `ob_addr` out 7: `oc*NWIN + win`.

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, NEXT, DONE.
- **IDLE**: `start`=1 → LOAD. Clears `oc`, `win`, `k`.
- **LOAD** (1 cycle): `fb_addr` and `bias_addr` are valid, covering the buffer's 1-cycle read latency. → RUN.
- **RUN** (`PASS_CYC` cycles):
  - `dp_valid_i`=1.
  - `wt_addr` advances each cycle with `k`=0..PASS_CYC-1.
  - After the last cycle → DRAIN; `k` clears.
- **DRAIN**:
  - `dp_valid_i`=0.
  - On `dp_valid_o`=1 → NEXT; `ob_we` pulses in the NEXT cycle with `ob_addr` for the pass just finished.
- **NEXT** (1 cycle):
  - `win` increments; at `win`=NWIN-1 it wraps to 0 and `oc` increments.
  - If `oc`=OUT_CH-1 and `win`=NWIN-1 → DONE, else → LOAD.
- **DONE**: `done`=1 for one cycle → IDLE.
- Loop order: `win` inner, `oc` outer. Total passes = `OUT_CH*NWIN` (72).
- `dp_valid_o` outside DRAIN is ignored; no write occurs.
- `start` while `busy` is ignored. `start` in the DONE cycle is ignored. A new run needs `start` while in IDLE.
- Address outputs are registered and hold their last value in IDLE/DRAIN/NEXT/DONE.

## Timing
- All outputs reset to 0: `busy`, `done`, `err`, `fb_addr`, `wt_addr`, `bias_addr`, `dp_valid_i`, `ob_we`, `ob_addr`. FSM resets to IDLE.
- Reset asserted mid-pass:
  - FSM → IDLE next edge, all counters clear, `dp_valid_i` drops the same edge.
  - No `ob_we`.
  - `err` clears.
- `start` sampled at cycle 0:
  - LOAD at cycle 1.
  - `dp_valid_i` high cycles 2..1+PASS_CYC.
  - DRAIN from cycle 2+PASS_CYC.
- If `dp_valid_o` arrives D cycles into DRAIN (D=0 meaning the first DRAIN cycle), `ob_we` comes D+1 cycles later. Pass period (LOAD to LOAD) = `PASS_CYC+3+D`.
- `dp_valid_i` is low for at least 3 cycles between passes (DRAIN, NEXT, LOAD). The datapath's internal phase counter therefore restarts each pass.

## Configuration
- `CONV2_CTRL_TIMEOUT_EN`:
  - **Defined**: a DRAIN cycle counter runs. If it reaches `DRAIN_MAX` without `dp_valid_o`:
    - `err` sets (sticky until `rst`);
    - no `ob_we`;
    - FSM → DONE, and `done` pulses.
    - A `dp_valid_o` in the same cycle the limit is reached counts as success.
  - **Undefined**: DRAIN waits indefinitely and `err` is tied to 0.

## Test plan
- **Nominal run**: defaults, bench returns `dp_valid_o` at D=2.
  - `start` at cycle 0 → `done` at cycle 1657.
  - 72 `ob_we` pulses.
  - `ob_addr` = 0..71 in order.
  - `busy` high cycles 1..1657.
- **Address check, pass 10** (`oc`=1, `win`=1):
  - `fb_addr`=2, `bias_addr`=1.
  - `wt_addr` steps 18..35 during RUN.
  - `ob_addr`=10.
- **Spurious strobe**: `dp_valid_o`=1 during RUN of pass 0 → no `ob_we`, FSM stays RUN, pass count unchanged.
- **Ignored start**: `start` held high through the whole run → only one run completes, and a second run begins only from IDLE, after `done`.
- **Reset mid-pass**: `rst` at RUN cycle 7 of pass 5 → next cycle all outputs are 0 and FSM is IDLE. A subsequent `start` begins at `ob_addr`=0.
- **Watchdog** (macro defined, `DRAIN_MAX`=15): bench withholds `dp_valid_o` on pass 3 → `err`=1 and `done` pulses 16 cycles after DRAIN entry, with exactly 3 `ob_we` pulses total.
